onehot_encoder_4_2: RTL and testbench

Registered 4-to-2 one-hot encoder: the inverse of the 2-to-4 predecoder. It recovers a 2-bit address from a 4-bit one-hot select/wordline group and flags illegal patterns. The block sits on the read-back/check path of the address decode logic. It is a 2-stage valid/ready pipeline with a saturating error counter, so decode faults can be checked at speed under backpressure.

---
 rtl/onehot_encoder_4_2.sv | 83 ++++++++
 tb/tb_onehot_encoder_4_2.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_encoder_4_2.sv
// Registered 4-to-2 one-hot encoder: two-stage valid/ready pipeline with a saturating error counter.
// Build option: define ONEHOT_ENC_PRIORITY_EN to encode multi-hot inputs to their lowest set bit.
module onehot_encoder_4_2 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    logic       s1_valid;
    logic [3:0] s1_data;
    logic       s2_load;
    logic [1:0] enc_out;
    logic       enc_err;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    always_comb begin
        enc_out = '0;
        enc_err = 1'b0;
`ifdef ONEHOT_ENC_PRIORITY_EN
        if      (s1_data[0]) enc_out = 2'd0;
        else if (s1_data[1]) enc_out = 2'd1;
        else if (s1_data[2]) enc_out = 2'd2;
        else if (s1_data[3]) enc_out = 2'd3;
        else                 enc_err = 1'b1;
`else
        case (s1_data)
            4'b0001: enc_out = 2'd0;
            4'b0010: enc_out = 2'd1;
            4'b0100: enc_out = 2'd2;
            4'b1000: enc_out = 2'd3;
            default: enc_err = 1'b1;
        endcase
`endif
    end

    // S1 refills whenever it is empty or drains into S2 on this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_data <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            err       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out <= enc_out;
                err <= enc_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_encoder_4_2.sv
// Self-checking bench for onehot_encoder_4_2: directed steps plus random traffic against a queue-based model.
module tb_onehot_encoder_4_2;

    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [1:0]       out;
    logic             err;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    onehot_encoder_4_2 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .err(err),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] val;   // {err, out}
        int         stamp; // edge index at which the sample was accepted
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    mcnt = 0;
    int    compared = 0;
    int    mismatched = 0;

    // Reference encoding straight from the rules: exactly one bit set -> its index
    function automatic logic [2:0] ref_enc(input logic [3:0] d);
        int unsigned n;
        n = $countones(d);
        if (n == 0) return 3'b100;
`ifndef ONEHOT_ENC_PRIORITY_EN
        if (n > 1) return 3'b100;
`endif
        for (int unsigned i = 0; i < 4; i++)
            if (d[i]) return {1'b0, 2'(i)};
        return 3'b100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] d, input logic ordy,
                        input logic clr, output bit acc);
        bit del, exp_ov, exp_ir;
        in_valid  = v;
        in        = d;
        out_ready = ordy;
        err_clr   = clr;
        @(negedge clk);
        exp_ov = (q.size() > 0) && (q[0].stamp != cyc - 1);
        exp_ir = !(q.size() == 2 && !ordy);
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("err_cnt", 32'(err_cnt), 32'(mcnt));
        if (exp_ov) begin
            check("out", 32'(out), 32'(q[0].val[1:0]));
            check("err", 32'(err), 32'(q[0].val[2]));
        end
        del = exp_ov && ordy;
        acc = v && exp_ir;
        if (clr) mcnt = 0;
        else if (del && q[0].val[2] && mcnt < CMAX) mcnt++;
        if (del) void'(q.pop_front());
        if (acc) q.push_back('{ref_enc(d), cyc});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic step_n(input logic v, input logic [3:0] d, input logic ordy, input int n);
        bit a;
        for (int k = 0; k < n; k++) step(v, d, ordy, 1'b0, a);
    endtask

    task automatic async_reset();
        in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        q.delete();
        mcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        logic [3:0] bp_data [4];
        logic [3:0] pend;
        bit         have, a;
        int         k, guard;

        // Power-on reset
        #2;
        check("por_out_valid", 32'(out_valid), 32'd0);
        check("por_out", 32'(out), 32'd0);
        check("por_err", 32'(err), 32'd0);
        check("por_err_cnt", 32'(err_cnt), 32'd0);
        check("por_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Legal stream at full rate
        step(1'b1, 4'b0001, 1'b1, 1'b0, a);
        step(1'b1, 4'b0010, 1'b1, 1'b0, a);
        step(1'b1, 4'b0100, 1'b1, 1'b0, a);
        step(1'b1, 4'b1000, 1'b1, 1'b0, a);
        step_n(1'b0, 4'b0000, 1'b1, 3);

        // All-zero and multi-hot
        step(1'b1, 4'b0000, 1'b1, 1'b0, a);
        step(1'b1, 4'b0011, 1'b1, 1'b0, a);
        step_n(1'b0, 4'b0000, 1'b1, 3);
        step(1'b0, 4'b0000, 1'b1, 1'b1, a);

        // Backpressure: producer holds each sample until accepted
        bp_data = '{4'b0100, 4'b0001, 4'b1000, 4'b0010};
        k = 0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, bp_data[k], 1'b0, 1'b0, a);
            if (a) k++;
        end
        check("bp_accepted", 32'(k), 32'd2);
        guard = 0;
        while (k < 4 && guard < 20) begin
            step(1'b1, bp_data[k], 1'b1, 1'b0, a);
            if (a) k++;
            guard++;
        end
        check("bp_all_accepted", 32'(k), 32'd4);
        step_n(1'b0, 4'b0000, 1'b1, 3);
        check("bp_drained", 32'(q.size()), 32'd0);

        // Saturation, then clear colliding with an errored transfer
        step(1'b0, 4'b0000, 1'b1, 1'b1, a);
        step_n(1'b1, 4'b0000, 1'b1, 5);
        step_n(1'b0, 4'b0000, 1'b1, 2);
        check("sat_cnt", 32'(err_cnt), 32'(CMAX));
        step(1'b1, 4'b0000, 1'b0, 1'b0, a);
        step(1'b0, 4'b0000, 1'b0, 1'b0, a);
        step(1'b0, 4'b0000, 1'b1, 1'b1, a);
        step(1'b0, 4'b0000, 1'b1, 1'b0, a);
        check("clr_wins", 32'(err_cnt), 32'd0);

        // Random traffic with a producer that honours the hold rule
        have = 1'b0;
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            if (!have && ($urandom_range(0, 3) != 0)) begin
                pend = ($urandom_range(0, 1) != 0) ? (4'b0001 << $urandom_range(0, 3))
                                                   : 4'($urandom_range(0, 15));
                have = 1'b1;
            end
            step(have, pend, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0), a);
            if (a) have = 1'b0;
        end
        step_n(1'b0, 4'b0000, 1'b1, 3);

        // Reset with both stages full and a non-zero counter
        step(1'b0, 4'b0000, 1'b1, 1'b1, a);
        step(1'b1, 4'b0000, 1'b1, 1'b0, a);
        step_n(1'b0, 4'b0000, 1'b1, 2);
        step(1'b1, 4'b0001, 1'b0, 1'b0, a);
        step(1'b1, 4'b0010, 1'b0, 1'b0, a);
        check("full_before_rst", 32'(q.size()), 32'd2);
        check("cnt_before_rst", 32'(err_cnt), 32'd1);
        async_reset();
        step(1'b1, 4'b1000, 1'b1, 1'b0, a);
        step(1'b0, 4'b0000, 1'b1, 1'b0, a);
        step(1'b0, 4'b0000, 1'b1, 1'b0, a);
        check("post_rst_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
